// File: rtl/col_parity_pkg.sv
// Shared types and constants for the column-parity engine.
// The optional theta-D result stage is selected with the macro COL_PARITY_THETA_D_EN.
package col_parity_pkg;

  localparam int NUM_LANES = 25;
  localparam int NUM_COLS  = 5;
  localparam int READ_LAT  = 1;

  localparam int LANE_BITS = 5;
  localparam int COL_BITS  = 3;

  typedef logic [LANE_BITS-1:0] lane_t;
  typedef logic [COL_BITS-1:0]  col_t;

  localparam lane_t LANE_LAST = lane_t'(NUM_LANES - 1);
  localparam col_t  COL_LAST  = col_t'(NUM_COLS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_TAIL,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Mod-5 column step; wraps 4 -> 0 without any division.
  function automatic col_t col_inc(input col_t c);
    return (c == COL_LAST) ? '0 : c + col_t'(1);
  endfunction

endpackage

// File: rtl/col_parity_acc.sv
// Five-column XOR accumulator bank with result selection.
// With COL_PARITY_THETA_D_EN defined the result is C[x-1] ^ rotl(C[x+1], 1); otherwise C[x].
module col_parity_acc
  import col_parity_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              acc_en,
  input  col_t              acc_col,
  input  logic [LANE_W-1:0] acc_data,
  input  col_t              sel_col,
  output logic [LANE_W-1:0] result
);

  logic [LANE_W-1:0] c_q     [NUM_COLS];
  logic [LANE_W-1:0] col_val [NUM_COLS];

  always_ff @(posedge clk) begin
    // NOTE: this small register bank is reset explicitly; it is flops, not a RAM, and every job must start from zero.
    if (rst || clear) begin
      for (int i = 0; i < NUM_COLS; i++) c_q[i] <= '0;
    end else if (acc_en) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        if (acc_col == col_t'(i)) c_q[i] <= c_q[i] ^ acc_data;
      end
    end
  end

`ifdef COL_PARITY_THETA_D_EN
  for (genvar x = 0; x < NUM_COLS; x++) begin : g_theta
    localparam int PREV = (x + NUM_COLS - 1) % NUM_COLS;
    localparam int NEXT = (x + 1) % NUM_COLS;
    assign col_val[x] = c_q[PREV] ^ {c_q[NEXT][LANE_W-2:0], c_q[NEXT][LANE_W-1]};
  end
`else
  for (genvar x = 0; x < NUM_COLS; x++) begin : g_plain
    assign col_val[x] = c_q[x];
  end
`endif

  always_comb begin
    result = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (sel_col == col_t'(i)) result = col_val[i];
    end
  end

endmodule

// File: rtl/col_parity_engine.sv
// Column-parity job engine: reads 25 lanes, folds them into five column parities, writes five results.
// Build option: define COL_PARITY_THETA_D_EN to emit theta-D column values instead of raw parities.
module col_parity_engine
  import col_parity_pkg::*;
#(
  parameter int LANE_W = 64,
  parameter int IDX_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IDX_W-1:0]   file_index,
  output logic               finish,
  output logic               busy,
  output logic               rd_en,
  output logic [IDX_W+4:0]   rd_addr,
  input  logic [LANE_W-1:0]  rd_data,
  output logic               wr_en,
  output logic [IDX_W+2:0]   wr_addr,
  output logic [LANE_W-1:0]  wr_data
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  lane_t            lane_q;
  col_t             col_q;
  logic             acc_en_q;
  col_t             acc_col_q;
  logic             accept;

  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // NOTE: every output and next-state variable gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    busy    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_READ;
      end
      ST_READ: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (lane_q == LANE_LAST) state_d = ST_TAIL;
      end
      ST_TAIL: begin
        busy    = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en = 1'b1;
        busy  = 1'b1;
        if (col_q == COL_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        finish = 1'b1;
        if (accept) state_d = ST_READ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      lane_q    <= '0;
      col_q     <= '0;
      acc_en_q  <= 1'b0;
      acc_col_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_en_q  <= rd_en;
      acc_col_q <= col_q;
      if (accept) begin
        idx_q  <= file_index;
        lane_q <= '0;
        col_q  <= '0;
      end else if (state_q == ST_READ) begin
        lane_q <= (lane_q == LANE_LAST) ? '0 : lane_q + lane_t'(1);
        col_q  <= col_inc(col_q);
      end else if (state_q == ST_WRITE) begin
        col_q  <= col_inc(col_q);
      end
    end
  end

  // Lane data lags rd_en by one cycle, so the accumulator uses the delayed strobe and column.
  col_parity_acc #(
    .LANE_W (LANE_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .acc_en   (acc_en_q),
    .acc_col  (acc_col_q),
    .acc_data (rd_data),
    .sel_col  (col_q),
    .result   (wr_data)
  );

  assign rd_addr = {idx_q, lane_q};
  assign wr_addr = {idx_q, col_q};

endmodule

// File: tb/tb_col_parity_engine.sv
// Scoreboard bench for col_parity_engine: a queue-based reference model predicts every read and write.
// Define COL_PARITY_THETA_D_EN for both bench and RTL to check the theta-D build.
module tb_col_parity_engine;

  localparam int LANE_W = 64;
  localparam int IDX_W  = 10;

  typedef logic [IDX_W+4:0] raddr_t;
  typedef logic [IDX_W+2:0] waddr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [IDX_W-1:0]  file_index;
  logic              finish;
  logic              busy;
  logic              rd_en;
  raddr_t            rd_addr;
  logic [LANE_W-1:0] rd_data;
  logic              wr_en;
  waddr_t            wr_addr;
  logic [LANE_W-1:0] wr_data;

  col_parity_engine #(
    .LANE_W (LANE_W),
    .IDX_W  (IDX_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .file_index (file_index),
    .finish     (finish),
    .busy       (busy),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Lane storage; unknown addresses return noise so stray reads corrupt results visibly.
  logic [63:0] mem [int];

  always @(posedge clk) begin
    if (rd_en === 1'b1 && mem.exists(int'(rd_addr))) rd_data <= mem[int'(rd_addr)];
    else rd_data <= {$urandom, $urandom};
  end

  raddr_t      rd_q [$];
  waddr_t      wa_q [$];
  logic [63:0] wd_q [$];
  int          rd_cnt;
  int          wr_cnt;

  // Monitor: every strobe the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    if (rd_en === 1'b1) begin
      rd_cnt++;
      if (rd_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_unexpected: got read at 0x%0h, expected no read", rd_addr);
      end else begin
        check("rd_addr", 64'(rd_addr), 64'(rd_q.pop_front()));
      end
    end
    if (wr_en === 1'b1) begin
      wr_cnt++;
      if (wa_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_unexpected: got write at 0x%0h, expected no write", wr_addr);
      end else begin
        check("wr_addr", 64'(wr_addr), 64'(wa_q.pop_front()));
        check("wr_data", wr_data, wd_q.pop_front());
      end
    end
  end

  logic [63:0] lanes [25];

  // Reference model: column x is the XOR of every lane i with i % 5 == x.
  task automatic push_job(input int idx, input int n_reads, input bit with_writes);
    logic [63:0] c [5];
    logic [63:0] r;
    for (int x = 0; x < 5; x++) c[x] = '0;
    for (int i = 0; i < 25; i++) begin
      mem[idx * 32 + i] = lanes[i];
      c[i % 5] = c[i % 5] ^ lanes[i];
      if (i < n_reads) rd_q.push_back(raddr_t'(idx * 32 + i));
    end
    if (with_writes) begin
      for (int x = 0; x < 5; x++) begin
`ifdef COL_PARITY_THETA_D_EN
        r = c[(x + 4) % 5] ^ ((c[(x + 1) % 5] << 1) | (c[(x + 1) % 5] >> 63));
`else
        r = c[x];
`endif
        wa_q.push_back(waddr_t'(idx * 8 + x));
        wd_q.push_back(r);
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 25; i++) lanes[i] = {$urandom, $urandom};
  endtask

  task automatic wait_busy(input logic val, input string name);
    int n = 0;
    while (busy !== val && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(busy), 64'(val));
  endtask

  task automatic run_job(input int idx);
    int n;
    push_job(idx, 25, 1'b1);
    rd_cnt = 0;
    wr_cnt = 0;
    @(negedge clk);
    start      = 1'b1;
    file_index = IDX_W'(idx);
    @(negedge clk);
    start = 1'b0;
    check("job_busy", 64'(busy), 64'(1));
    n = 1;
    while (finish !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("finish_latency", 64'(n), 64'(32));
    check("read_count", 64'(rd_cnt), 64'(25));
    check("write_count", 64'(wr_cnt), 64'(5));
    repeat (3) @(negedge clk);
    check("finish_hold", 64'(finish), 64'(1));
    check("done_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst        = 1'b1;
    start      = 1'b0;
    file_index = '0;
    rd_cnt     = 0;
    wr_cnt     = 0;
    repeat (3) @(negedge clk);
    check("rst_finish", 64'(finish), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rd_en", 64'(rd_en), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_rd_addr", 64'(rd_addr), 64'(0));
    check("rst_wr_addr", 64'(wr_addr), 64'(0));
    check("rst_wr_data", wr_data, 64'(0));

    // Reset wins over a simultaneous start.
    start      = 1'b1;
    file_index = 10'd9;
    @(negedge clk);
    check("rst_prio_busy", 64'(busy), 64'(0));
    check("rst_prio_rd_en", 64'(rd_en), 64'(0));
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));

    // All-zero lanes at index 0.
    for (int i = 0; i < 25; i++) lanes[i] = '0;
    run_job(0);

    // Lane i holds i+1.
    for (int i = 0; i < 25; i++) lanes[i] = 64'(i + 1);
    run_job(5);

    // Single set bit in lane 7.
    for (int i = 0; i < 25; i++) lanes[i] = '0;
    lanes[7] = 64'h1;
    run_job(1);

    // Random full-width lanes, random indices.
    for (int j = 0; j < 4; j++) begin
      fill_random();
      run_job(int'($urandom_range(0, 1023)));
    end

    // start held for three cycles yields a single job.
    fill_random();
    push_job(4, 25, 1'b1);
    rd_cnt = 0;
    wr_cnt = 0;
    @(negedge clk);
    start      = 1'b1;
    file_index = 10'd4;
    repeat (3) @(negedge clk);
    start = 1'b0;
    n = 0;
    while (finish !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("held_finish", 64'(finish), 64'(1));
    repeat (40) @(negedge clk);
    check("held_read_count", 64'(rd_cnt), 64'(25));
    check("held_write_count", 64'(wr_cnt), 64'(5));

    // Back-to-back jobs 0,1,2 with start held; index changes mid-job are ignored.
    for (int j = 0; j < 3; j++) begin
      fill_random();
      push_job(j, 25, 1'b1);
    end
    rd_cnt = 0;
    wr_cnt = 0;
    @(negedge clk);
    start      = 1'b1;
    file_index = 10'd0;
    for (int j = 0; j < 3; j++) begin
      wait_busy(1'b1, "b2b_busy_rise");
      file_index = (j == 2) ? 10'd7 : IDX_W'(j + 1);
      if (j == 2) start = 1'b0;
      wait_busy(1'b0, "b2b_busy_fall");
      check("b2b_finish", 64'(finish), 64'(1));
      if (j < 2) begin
        @(negedge clk);
        check("b2b_finish_pulse", 64'(finish), 64'(0));
      end
    end
    repeat (5) @(negedge clk);
    check("b2b_finish_hold", 64'(finish), 64'(1));
    check("b2b_read_count", 64'(rd_cnt), 64'(75));
    check("b2b_write_count", 64'(wr_cnt), 64'(15));

    // Reset during lane 12 abandons the job.
    fill_random();
    push_job(6, 13, 1'b0);
    rd_cnt = 0;
    wr_cnt = 0;
    @(negedge clk);
    start      = 1'b1;
    file_index = 10'd6;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(rd_en === 1'b1 && rd_addr[4:0] == 5'd12) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_lane12", 64'(rd_addr[4:0]), 64'(12));
    rst = 1'b1;
    @(negedge clk);
    check("abort_rd_en", 64'(rd_en), 64'(0));
    check("abort_finish", 64'(finish), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_finish_low", 64'(finish), 64'(0));
    check("abort_read_count", 64'(rd_cnt), 64'(13));
    check("abort_write_count", 64'(wr_cnt), 64'(0));

    fill_random();
    run_job(3);

    check("rd_queue_empty", 64'(rd_q.size()), 64'(0));
    check("wr_queue_empty", 64'(wa_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
